// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: two 1-entry buffers (ALU = A, load = B) share the single
// register-file write port. Oldest-first grant, round-robin on ties.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [ADDR_W-1:0]    a_addr,
  input  logic [DATA_W-1:0]    a_data,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [ADDR_W-1:0]    b_addr,
  input  logic [DATA_W-1:0]    b_data,
  output logic [ADDR_W-1:0]    rf_addrssw,
  output logic                 rf_write,
  output logic [DATA_W-1:0]    rf_write_material,
  output logic [2**ADDR_W-1:0] pending_mask
);

  logic              full_a, full_b;
  logic [ADDR_W-1:0] addr_a, addr_b;
  logic [DATA_W-1:0] data_a, data_b;
  // age_x=1: this entry arrived strictly before the other buffered one.
  // Both 0 with both buffers full means they arrived on the same edge.
  logic              age_a, age_b;
  logic              tie_ptr;

  logic grant_a, grant_b, tie;
  logic acc_a, acc_b, nfull_a, nfull_b;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    tie     = full_a && full_b && !age_a && !age_b;
    if (full_a && full_b) begin
      if (age_a)         grant_a = 1'b1;
      else if (age_b)    grant_b = 1'b1;
      else if (!tie_ptr) grant_a = 1'b1;
      else               grant_b = 1'b1;
    end else begin
      grant_a = full_a;
      grant_b = full_b;
    end
  end

  assign a_ready = !rst && (!full_a || grant_a);
  assign b_ready = !rst && (!full_b || grant_b);
  assign acc_a   = a_valid && a_ready;
  assign acc_b   = b_valid && b_ready;
  assign nfull_a = acc_a || (full_a && !grant_a);
  assign nfull_b = acc_b || (full_b && !grant_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      full_a            <= 1'b0;
      full_b            <= 1'b0;
      addr_a            <= '0;
      addr_b            <= '0;
      data_a            <= '0;
      data_b            <= '0;
      age_a             <= 1'b0;
      age_b             <= 1'b0;
      tie_ptr           <= 1'b0;
      rf_write          <= 1'b0;
      rf_addrssw        <= '0;
      rf_write_material <= '0;
    end else begin
      full_a <= nfull_a;
      full_b <= nfull_b;
      if (acc_a) begin
        addr_a <= a_addr;
        data_a <= a_data;
      end
      if (acc_b) begin
        addr_b <= b_addr;
        data_b <= b_data;
      end
      // A lone arrival is younger than whatever stays buffered on the other side.
      if (acc_a && acc_b) begin
        age_a <= 1'b0;
        age_b <= 1'b0;
      end else if (acc_a) begin
        age_a <= 1'b0;
        age_b <= nfull_b;
      end else if (acc_b) begin
        age_b <= 1'b0;
        age_a <= nfull_a;
      end
      if (tie) tie_ptr <= ~tie_ptr;
      rf_write <= (grant_a && addr_a != '0) || (grant_b && addr_b != '0);
      if (grant_a) begin
        rf_addrssw        <= addr_a;
        rf_write_material <= data_a;
      end else if (grant_b) begin
        rf_addrssw        <= addr_b;
        rf_write_material <= data_b;
      end
    end
  end

  always_comb begin
    pending_mask = '0;
    if (full_a)   pending_mask[addr_a]     = 1'b1;
    if (full_b)   pending_mask[addr_b]     = 1'b1;
    if (rf_write) pending_mask[rf_addrssw] = 1'b1;
    pending_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: per-channel scoreboard of accepted beats checked
// against the write port, plus cycle-exact directed checks.
module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, a_ready, b_ready;
  logic [4:0]  a_addr, b_addr, rf_addrssw;
  logic [31:0] a_data, b_data, rf_write_material, pending_mask;
  logic        rf_write;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_t;
  wb_t         qa[$], qb[$];
  logic [31:0] rf_model[32];

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .rf_addrssw(rf_addrssw), .rf_write(rf_write),
    .rf_write_material(rf_write_material), .pending_mask(pending_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                     input logic bv, input logic [4:0] ba, input logic [31:0] bd);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
  endtask

  // Scoreboard: each write must be the oldest outstanding beat of some channel.
  always @(negedge clk) begin
    if (rst) begin
      qa.delete();
      qb.delete();
    end else begin
      if (rf_write) begin
        logic hit;
        hit = 1'b0;
        if (qa.size() > 0 && qa[0].addr == rf_addrssw && qa[0].data == rf_write_material) begin
          void'(qa.pop_front());
          hit = 1'b1;
        end else if (qb.size() > 0 && qb[0].addr == rf_addrssw && qb[0].data == rf_write_material) begin
          void'(qb.pop_front());
          hit = 1'b1;
        end
        chk("wb_match", {27'd0, rf_addrssw, rf_write_material}, hit ? {27'd0, rf_addrssw, rf_write_material} : 64'hFFFF_FFFF_FFFF_FFFF);
        rf_model[rf_addrssw] = rf_write_material;
      end
      if (a_valid && a_ready && a_addr != 5'd0) qa.push_back('{a_addr, a_data});
      if (b_valid && b_ready && b_addr != 5'd0) qb.push_back('{b_addr, b_data});
    end
  end

  initial begin
    int na, nb;
    logic [4:0] prev;
    for (int i = 0; i < 32; i++) rf_model[i] = '0;
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_write", rf_write, 0);
    chk("rst_addr", rf_addrssw, 0);
    chk("rst_data", rf_write_material, 0);
    chk("rst_mask", pending_mask, 0);
    cyc(); rst = 1'b0;
    @(negedge clk);
    chk("post_rst_a_ready", a_ready, 1);
    chk("post_rst_b_ready", b_ready, 1);

    // Single request
    cyc(); drv(1, 5, 32'hDEADBEEF, 0, 0, 0); @(negedge clk);
    cyc(); drv(0, 0, 0, 0, 0, 0); @(negedge clk);
    chk("single_mask", pending_mask, 32'h20);
    chk("single_nowr", rf_write, 0);
    cyc(); @(negedge clk);
    chk("single_wr", rf_write, 1);
    chk("single_addr", rf_addrssw, 5);
    chk("single_data", rf_write_material, 32'hDEADBEEF);
    cyc(); @(negedge clk);
    chk("single_done", rf_write, 0);
    chk("single_mask0", pending_mask, 0);

    // Simultaneous requests, twice: tie pointer alternates the winner
    cyc(); drv(1, 3, 32'h11, 1, 4, 32'h22); @(negedge clk);
    cyc(); drv(0, 0, 0, 0, 0, 0); @(negedge clk);
    chk("tie1_mask", pending_mask, 32'h18);
    cyc(); @(negedge clk);
    chk("tie1_first", rf_addrssw, 3);
    chk("tie1_first_d", rf_write_material, 32'h11);
    cyc(); @(negedge clk);
    chk("tie1_second", rf_addrssw, 4);
    chk("tie1_second_d", rf_write_material, 32'h22);
    cyc(); drv(1, 3, 32'h33, 1, 4, 32'h44); @(negedge clk);
    cyc(); drv(0, 0, 0, 0, 0, 0); @(negedge clk);
    cyc(); @(negedge clk);
    chk("tie2_first", rf_addrssw, 4);
    chk("tie2_first_d", rf_write_material, 32'h44);
    cyc(); @(negedge clk);
    chk("tie2_second", rf_addrssw, 3);
    chk("tie2_second_wr", rf_write, 1);

    // Same-register ordering: B's 0xAA waits behind A, then A's 0xBB follows it
    cyc(); drv(1, 1, 32'h01, 0, 0, 0); @(negedge clk);
    cyc(); drv(1, 6, 32'h66, 1, 7, 32'hAA); @(negedge clk);
    chk("ord_a_ready", a_ready, 1);
    cyc(); drv(1, 7, 32'hBB, 0, 0, 0); @(negedge clk);
    chk("ord_a_ready2", a_ready, 1);
    chk("ord_w1", rf_addrssw, 1);
    cyc(); drv(0, 0, 0, 0, 0, 0); @(negedge clk);
    chk("ord_w6", rf_write_material, 32'h66);
    cyc(); @(negedge clk);
    chk("ord_aa_addr", rf_addrssw, 7);
    chk("ord_aa", rf_write_material, 32'hAA);
    cyc(); @(negedge clk);
    chk("ord_bb_addr", rf_addrssw, 7);
    chk("ord_bb", rf_write_material, 32'hBB);
    repeat (2) cyc();
    @(negedge clk);
    chk("ord_final", rf_model[7], 32'hBB);

    // Streaming: both channels valid for 10 cycles
    na = 0; nb = 0; prev = '0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      drv(1, 8, 32'hA00 + na, 1, 9, 32'hB00 + nb);
      @(negedge clk);
      if (i >= 1) chk("strm_one_ready", a_ready ^ b_ready, 1);
      if (i >= 2) chk("strm_write", rf_write, 1);
      if (i >= 3) chk("strm_alt", rf_addrssw != prev, 1);
      prev = rf_addrssw;
      if (a_ready) na++;
      if (b_ready) nb++;
    end
    cyc(); drv(0, 0, 0, 0, 0, 0);
    repeat (4) cyc();
    @(negedge clk);
    chk("strm_drain_a", qa.size(), 0);
    chk("strm_drain_b", qb.size(), 0);

    // Register 0: accepted, never written, still uses a grant slot
    cyc(); drv(1, 0, 32'hFFFFFFFF, 1, 10, 32'h55); @(negedge clk);
    chk("r0_a_ready", a_ready, 1);
    cyc(); drv(0, 0, 0, 0, 0, 0); @(negedge clk);
    chk("r0_mask", pending_mask, 32'h400);
    cyc(); @(negedge clk);
    chk("r0_nowr", rf_write, 0);
    chk("r0_mask_b0", pending_mask[0], 0);
    cyc(); @(negedge clk);
    chk("r0_b_wr", rf_write, 1);
    chk("r0_b_addr", rf_addrssw, 10);
    chk("r0_b_data", rf_write_material, 32'h55);

    // Reset with both buffers full and a write on the port
    cyc(); drv(1, 11, 32'h111, 1, 12, 32'h222); @(negedge clk);
    cyc(); drv(0, 0, 0, 1, 13, 32'h333); @(negedge clk);
    cyc(); drv(0, 0, 0, 0, 0, 0); @(negedge clk);
    chk("mid_wr_before", rf_write, 1);
    chk("mid_mask_before", pending_mask, 32'h3800);
    cyc(); rst = 1'b1; @(negedge clk);
    chk("mid_rst_ready", a_ready | b_ready, 0);
    cyc(); rst = 1'b0; @(negedge clk);
    chk("mid_wr", rf_write, 0);
    chk("mid_mask", pending_mask, 0);
    chk("mid_ready", {a_ready, b_ready}, 2'b11);
    for (int i = 0; i < 5; i++) begin
      cyc(); @(negedge clk);
      chk("mid_no_write", rf_write, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter that shares the register file's single write port (`addrssw` / `write` / `write_material`) between two requesters: the ALU result path (channel A) and the load/memory path (channel B). Each channel has a 1-entry holding buffer with a valid/ready handshake. Arbitration is oldest-first, with round-robin on ties, and grants at most one write per cycle. The block also publishes a pending-write mask so ID can stall on registers that are still in flight.

## Interface
- `DATA_W`, 32, write data width
- `ADDR_W`, 5, register address width; the mask width is 2**ADDR_W

- `clk`  in  1  sole clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `a_valid`  in  1  ALU write-back request
- `a_ready`  out  1  channel A can accept this cycle
- `a_addr`  in  ADDR_W  destination register
- `a_data`  in  DATA_W  result
- `b_valid`, `b_ready`, `b_addr`, `b_data`: same as channel A, for the load path
- `rf_addrssw`  out  ADDR_W  registered; drives regfile `addrssw`
- `rf_write`  out  1  registered; drives regfile `write`
- `rf_write_material`  out  DATA_W  registered; drives regfile `write_material`
- `pending_mask`  out  2**ADDR_W  bit r=1 while a write to register r is buffered or on the write port

## Operation
- **Per-channel state.** Each channel holds `full_x`, `addr_x`, `data_x` and `age_x`.
- **Block state.** `tie_ptr`: 0 means A wins the next tie.
- **Accept.** A channel accepts when `x_valid && x_ready`. At the edge:
  - `full_x` is set to 1.
  - `addr_x` and `data_x` are captured.
  - `age_x` records arrival order.
- **Ready.** `x_ready = !rst && (!full_x || grant_x)`. A channel can therefore drain and refill on the same edge.
- **Grant** (combinational, from buffer state only):
  - Only one buffer full: that channel is granted.
  - Both full, different arrival edges: the older entry is granted.
  - Both full, same arrival edge: the channel selected by `tie_ptr` is granted, and `tie_ptr` toggles.
- **On a grant edge:**
  - `rf_addrssw` and `rf_write_material` take the granted entry.
  - `rf_write` = (granted `addr != 0`).
  - The granted buffer clears unless it refills on the same edge.
  - The losing buffer stays full and becomes the oldest entry.
- **No grant.** `rf_write` = 0. `rf_addrssw` and `rf_write_material` hold their previous values.
- **Register 0.**
  - Entries addressed to register 0 are accepted and consume a grant slot.
  - `rf_write` stays 0 for them (the write is discarded).
  - They never set bit 0 of `pending_mask`.
- **Pending mask.**
  - `pending_mask` = decode(`addr_a`) if `full_a` | decode(`addr_b`) if `full_b` | decode(`rf_addrssw`) if `rf_write`.
  - It is combinational from registered state, with bit 0 forced to 0.
- **Same-address entries.** When both buffers target the same register, the write order equals the arrival order. The oldest-first rule guarantees this.
- **Inputs ignored.** `x_addr` and `x_data` are ignored when no accept occurs.

## Timing
- **Reset values** (at the first edge with `rst`=1):
  - `full_a`, `full_b` = 0; `tie_ptr` = 0.
  - `rf_write` = 0, `rf_addrssw` = 0, `rf_write_material` = 0.
  - `pending_mask` = 0.
  - `a_ready`, `b_ready` = 0 while `rst`=1, and 1 in the first cycle after reset deasserts.
- **Reset mid-operation.** Buffered entries are dropped with no write, and any `rf_write` in flight is cleared at that edge.
- **Latency.** Accept at edge E0; `rf_write`=1 during cycle E1→E2; the register file commits at E2. This gives 2 edges from accept to commit when uncontested.
- **Contested latency.** The loser commits one edge later.
- **Throughput.** One write per cycle in aggregate. With both channels streaming continuously, grants alternate A, B, A, B. Each channel sustains 1 accept per 2 cycles; `x_ready` drops on its losing cycles.
- **Write pulse.** `rf_write` is a single-cycle pulse per grant. Back-to-back grants give consecutive pulses.
- **Mask timing.** A `pending_mask` bit rises in the cycle after accept and falls in the cycle after the register file commits.
- **Bypass.** There is no combinational path from `x_valid` to `rf_*`.

## Test plan
- **Single request.** After reset, A sends addr 5 / data 0xDEADBEEF for one cycle.
  - Next cycle: `pending_mask` = 0x20.
  - Cycle after: `rf_write`=1, addr 5, data 0xDEADBEEF.
  - Then `rf_write`=0 and mask = 0.
- **Simultaneous requests.** A (addr 3, 0x11) and B (addr 4, 0x22) arrive on the same edge. A is written first, then B (`tie_ptr` was 0). A repeated tie grants B first.
- **Ordering.** B writes addr 7 = 0xAA, and one cycle later A writes addr 7 = 0xBB while B is still buffered behind an earlier grant. The write port shows 0xAA, then 0xBB; the final regfile value is 0xBB.
- **Streaming.** Both channels hold valid high for 10 cycles with incrementing data. Expect:
  - Exactly one `rf_write` per cycle, with the channel source alternating.
  - Every accepted beat appears exactly once, in per-channel order.
  - `x_ready` is 0 on each channel's losing cycles.
- **Register 0.** A writes addr 0 = 0xFFFFFFFF. Expect `a_ready`=1, `rf_write` never asserted, `pending_mask` bit 0 = 0, and the grant slot consumed (a B request pending at the same time waits one cycle).
- **Reset mid-operation.** Both buffers are full and `rf_write`=1 when `rst` is pulsed for 1 cycle. Next cycle: `rf_write`=0, mask 0, no later writes; readies return to 1 after `rst` falls.
